rnn_seq_ctrl: RTL and testbench
===============================

RNN_SEQ_CTRL -- requirements
Module: rnn_seq_ctrl

Interface
- REQ-001: Parameter NUM_STAGES, default 6: number of chained compute stages, executed in order 0..NUM_STAGES-1; legal range 2..8.
- REQ-002: Parameter IDX_W, default 3: stage-index width; NUM_STAGES SHALL be <= 2**IDX_W.
- REQ-003: Parameter STATE_MASK, NUM_STAGES bits, default 6'b011010: bit i set means stage i is recurrent and owns a state register.
- REQ-004: Parameter TIMEOUT_W, default 16; parameter TIMEOUT, default 4096: maximum wait cycles per stage; 0 disables the timeout.
- REQ-005: Parameter CNT_W, default 16: frame counter width.
- REQ-006: clk  in  1  sole clock; all state updates on its rising edge.
- REQ-007: rst_n  in  1  asynchronous, active-low reset.
- REQ-008: start  in  1  frame request; level, sampled each cycle.
- REQ-009: abort  in  1  synchronous frame cancel.
- REQ-010: state_clear  in  1  request to zero all recurrent state registers.
- REQ-011: stage_valid  in  NUM_STAGES  per-stage completion, one bit per stage.
- REQ-012: stage_start  out  NUM_STAGES  one-cycle start pulse to stage i.
- REQ-013: state_load  out  NUM_STAGES  one-cycle capture strobe for stage i's state register.
- REQ-014: state_clr  out  1  one-cycle clear strobe to all state registers.
- REQ-015: busy  out  1  frame in progress.
- REQ-016: frame_done  out  1  one-cycle pulse on frame completion.
- REQ-017: timeout_err  out  1  sticky stage-timeout flag.
- REQ-018: err_stage  out  IDX_W  index of the stage that timed out.
- REQ-019: overrun  out  1  sticky flag: start seen while busy.
- REQ-020: frame_cnt  out  CNT_W  count of completed frames; wraps to 0 after all-ones.

Function
- REQ-021: FSM states SHALL be IDLE, ISSUE and WAIT, with a stage index idx.
- REQ-022: In IDLE, start=1 SHALL set idx=0, clear timeout_err and overrun, and go to ISSUE.
- REQ-023: ISSUE SHALL last exactly one cycle, drive stage_start[idx]=1 (all other bits 0), load the timeout counter with 0, and go to WAIT.
- REQ-024: In WAIT, stage_valid[idx]=1 SHALL end the stage; stage_valid bits for other stages SHALL be ignored in all states.
- REQ-025: On stage end with idx<NUM_STAGES-1, the next cycle SHALL be ISSUE for idx+1; state_load[idx] SHALL pulse in that same cycle if STATE_MASK[idx]=1.
- REQ-026: On stage end with idx=NUM_STAGES-1, the next cycle SHALL assert frame_done, increment frame_cnt (pulse state_load[idx] if masked), and enter IDLE.
- REQ-027: Latency: start accepted at edge k -> stage_start[0] high in cycle k+1; valid sampled at edge m -> next stage start (or frame_done) high in cycle m+1.
- REQ-028: busy SHALL be 1 in ISSUE and WAIT and 0 in IDLE, including the frame_done cycle.
- REQ-029: A start seen in ISSUE or WAIT SHALL be ignored and SHALL set overrun.
- REQ-030: A start seen in the frame_done cycle SHALL be accepted as a new frame.
- REQ-031: With TIMEOUT!=0, reaching TIMEOUT WAIT cycles without the expected valid SHALL:
  - set timeout_err;
  - set err_stage=idx;
  - return to IDLE with no frame_done and no state_load.
- REQ-032: abort=1 in ISSUE or WAIT SHALL return to IDLE next cycle with no frame_done or state_load; abort SHALL have priority over a simultaneous stage_valid; abort in IDLE has no effect.
- REQ-033: state_clear in IDLE SHALL pulse state_clr in the next cycle.
- REQ-034: state_clear while busy SHALL be latched and pulse state_clr in the first IDLE cycle after the frame ends, completes, times out or aborts.
- REQ-035: At most one stage_start bit and at most one state_load bit SHALL be high in any cycle.

Reset
- REQ-036: rst_n=0 SHALL immediately force the following, regardless of the clock:
  - IDLE, idx=0, frame_cnt=0, err_stage=0;
  - all strobes 0, busy=0, timeout_err=0, overrun=0;
  - any pending state_clear latch discarded.
- REQ-037: Reset asserted mid-frame SHALL abandon the frame with no frame_done; the first start after rst_n rises SHALL begin at stage 0.

Verification
- REQ-038: Default parameters, start pulse, each stage returns valid 3 cycles after its start -> stage_start bits pulse 0..5 in order; state_load pulses for stages 1, 3, 4 only; frame_done pulses once; frame_cnt=1.
- REQ-039: TIMEOUT=8, stage 2 never returns valid -> timeout_err=1, err_stage=2, busy=0, no frame_done; next start clears timeout_err.
- REQ-040: Start repeated during a frame, and start held high through frame_done -> overrun=1; a second frame begins the cycle after frame_done; frame_cnt=2.
- REQ-041: state_clear while in stage 3 -> no state_clr until frame_done; state_clr pulses once in the following cycle.
- REQ-042: abort and stage_valid[4] in the same cycle -> IDLE, no state_load[4], no frame_done.
- REQ-043: frame_cnt preset near wrap via 2**CNT_W frames (CNT_W=4), then rst_n pulsed mid-frame -> frame_cnt wraps 15->0; after reset all outputs are 0.

Source files
------------

// File: rtl/rnn_seq_ctrl.sv
// Sequencer for a chain of RNN compute stages. Starts each stage in turn, waits for
// its completion, strobes recurrent state capture, and tracks frames, timeouts and
// overruns. All strobes are registered one-cycle pulses except stage_start_o, which
// is decoded from the ISSUE state.
module rnn_seq_ctrl #(
  parameter int unsigned                  NUM_STAGES = 6,
  parameter int unsigned                  IDX_W      = 3,
  parameter logic [NUM_STAGES-1:0]        STATE_MASK = 6'b011010,
  parameter int unsigned                  TIMEOUT_W  = 16,
  parameter int unsigned                  TIMEOUT    = 4096,
  parameter int unsigned                  CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic                  abort_i,
  input  logic                  state_clear_i,
  input  logic [NUM_STAGES-1:0] stage_valid_i,
  output logic [NUM_STAGES-1:0] stage_start_o,
  output logic [NUM_STAGES-1:0] state_load_o,
  output logic                  state_clr_o,
  output logic                  busy_o,
  output logic                  frame_done_o,
  output logic                  timeout_err_o,
  output logic [IDX_W-1:0]      err_stage_o,
  output logic                  overrun_o,
  output logic [CNT_W-1:0]      frame_cnt_o
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

  localparam logic [IDX_W-1:0]     LastIdx = IDX_W'(NUM_STAGES - 1);
  // Compare value for the last permitted WAIT cycle; unused when TIMEOUT is 0.
  localparam logic [TIMEOUT_W-1:0] TmoLast = TIMEOUT_W'(TIMEOUT - 1);

  state_e                  st_q, st_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [TIMEOUT_W-1:0]    tmo_q, tmo_d;
  logic [NUM_STAGES-1:0]   load_q, load_d;
  logic                    done_q, done_d;
  logic                    clr_q, clr_d;
  logic                    pend_q, pend_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    terr_q, terr_d;
  logic [IDX_W-1:0]        estage_q, estage_d;
  logic                    ovr_q, ovr_d;

  // State register; reset abandons any frame and drops a pending clear request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q     <= StIdle;
      idx_q    <= '0;
      tmo_q    <= '0;
      load_q   <= '0;
      done_q   <= 1'b0;
      clr_q    <= 1'b0;
      pend_q   <= 1'b0;
      cnt_q    <= '0;
      terr_q   <= 1'b0;
      estage_q <= '0;
      ovr_q    <= 1'b0;
    end else begin
      st_q     <= st_d;
      idx_q    <= idx_d;
      tmo_q    <= tmo_d;
      load_q   <= load_d;
      done_q   <= done_d;
      clr_q    <= clr_d;
      pend_q   <= pend_d;
      cnt_q    <= cnt_d;
      terr_q   <= terr_d;
      estage_q <= estage_d;
      ovr_q    <= ovr_d;
    end
  end

  // Next-state logic: abort beats stage completion, completion beats timeout.
  always_comb begin
    st_d     = st_q;
    idx_d    = idx_q;
    tmo_d    = tmo_q;
    load_d   = '0;
    done_d   = 1'b0;
    clr_d    = 1'b0;
    pend_d   = pend_q;
    cnt_d    = cnt_q;
    terr_d   = terr_q;
    estage_d = estage_q;
    ovr_d    = ovr_q;

    if (st_q != StIdle) begin
      if (start_i)       ovr_d  = 1'b1;
      if (state_clear_i) pend_d = 1'b1;
    end

    unique case (st_q)
      StIdle: begin
        if (state_clear_i || pend_q) begin
          clr_d  = 1'b1;
          pend_d = 1'b0;
        end
        if (start_i) begin
          st_d   = StIssue;
          idx_d  = '0;
          terr_d = 1'b0;
          ovr_d  = 1'b0;
        end
      end
      StIssue: begin
        tmo_d = '0;
        st_d  = abort_i ? StIdle : StWait;
      end
      StWait: begin
        if (abort_i) begin
          st_d = StIdle;
        end else if (stage_valid_i[idx_q]) begin
          load_d[idx_q] = STATE_MASK[idx_q];
          if (idx_q == LastIdx) begin
            st_d   = StIdle;
            done_d = 1'b1;
            cnt_d  = cnt_q + 1'b1;
          end else begin
            st_d  = StIssue;
            idx_d = idx_q + 1'b1;
          end
        end else if ((TIMEOUT != 0) && (tmo_q == TmoLast)) begin
          st_d     = StIdle;
          terr_d   = 1'b1;
          estage_d = idx_q;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      default: st_d = StIdle;
    endcase
  end

  // Output decode: stage start is one-hot on idx while in ISSUE.
  always_comb begin
    stage_start_o = '0;
    if (st_q == StIssue) stage_start_o[idx_q] = 1'b1;
  end

  assign busy_o        = (st_q != StIdle);
  assign state_load_o  = load_q;
  assign state_clr_o   = clr_q;
  assign frame_done_o  = done_q;
  assign timeout_err_o = terr_q;
  assign err_stage_o   = estage_q;
  assign overrun_o     = ovr_q;
  assign frame_cnt_o   = cnt_q;

endmodule

// File: tb/tb_rnn_seq_ctrl.sv
// Bench for rnn_seq_ctrl: directed frame scenarios plus random stimulus, all compared
// cycle by cycle against a frame-level behavioural model.
module tb_rnn_seq_ctrl;

  localparam int          N    = 6;
  localparam int          TMO  = 8;
  localparam int          CW   = 4;
  localparam logic [N-1:0] MASK = 6'b011010;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0, abort = 1'b0, state_clear = 1'b0;
  logic [N-1:0]  stage_valid = '0;
  logic [N-1:0]  stage_start, state_load;
  logic          state_clr, busy, frame_done, timeout_err, overrun;
  logic [2:0]    err_stage;
  logic [CW-1:0] frame_cnt;

  rnn_seq_ctrl #(
    .NUM_STAGES(N), .IDX_W(3), .STATE_MASK(MASK), .TIMEOUT_W(16), .TIMEOUT(TMO), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start), .abort_i(abort), .state_clear_i(state_clear),
    .stage_valid_i(stage_valid), .stage_start_o(stage_start), .state_load_o(state_load),
    .state_clr_o(state_clr), .busy_o(busy), .frame_done_o(frame_done),
    .timeout_err_o(timeout_err), .err_stage_o(err_stage), .overrun_o(overrun),
    .frame_cnt_o(frame_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: a frame walks stages 0..N-1; each stage is "just started" for
  // one cycle, then waits for its own valid, an abort or TMO idle cycles.
  bit m_act, m_fresh, m_done, m_clr, m_pend, m_terr, m_ovr;
  int m_stage, m_wait, m_load, m_cnt, m_estage;

  // Observations gathered while checking.
  logic [N-1:0] starts_seen[$];
  logic [N-1:0] loads_seen;
  int           done_seen, clr_seen;

  task automatic model_reset();
    m_act = 0; m_fresh = 0; m_done = 0; m_clr = 0; m_pend = 0; m_terr = 0; m_ovr = 0;
    m_stage = 0; m_wait = 0; m_load = -1; m_cnt = 0; m_estage = 0;
  endtask

  task automatic model_step(input bit s, input bit a, input bit c, input logic [N-1:0] v);
    m_load = -1; m_done = 0; m_clr = 0;
    if (!m_act) begin
      if (c || m_pend) begin m_clr = 1; m_pend = 0; end
      if (s) begin m_act = 1; m_fresh = 1; m_stage = 0; m_terr = 0; m_ovr = 0; end
    end else begin
      if (s) m_ovr = 1;
      if (c) m_pend = 1;
      if (a) begin
        m_act = 0;
      end else if (m_fresh) begin
        m_fresh = 0; m_wait = 0;
      end else if (v[m_stage]) begin
        if (MASK[m_stage]) m_load = m_stage;
        if (m_stage == N - 1) begin
          m_act = 0; m_done = 1; m_cnt = (m_cnt + 1) % (1 << CW);
        end else begin
          m_stage++; m_fresh = 1;
        end
      end else begin
        m_wait++;
        if (m_wait == TMO) begin m_act = 0; m_terr = 1; m_estage = m_stage; end
      end
    end
  endtask

  task automatic check_outputs();
    check("stage_start", stage_start, (m_act && m_fresh) ? (32'd1 << m_stage) : 32'd0);
    check("state_load", state_load, (m_load >= 0) ? (32'd1 << m_load) : 32'd0);
    check("state_clr", state_clr, m_clr);
    check("busy", busy, m_act);
    check("frame_done", frame_done, m_done);
    check("timeout_err", timeout_err, m_terr);
    check("err_stage", err_stage, m_estage);
    check("overrun", overrun, m_ovr);
    check("frame_cnt", frame_cnt, m_cnt);
    if (stage_start != 0) starts_seen.push_back(stage_start);
    loads_seen |= state_load;
    if (frame_done) done_seen++;
    if (state_clr) clr_seen++;
  endtask

  // One clock cycle, entered and left at a falling edge.
  task automatic cyc(input bit s, input bit a, input bit c, input logic [N-1:0] v);
    check_outputs();
    start = s; abort = a; state_clear = c; stage_valid = v;
    model_step(s, a, c, v);
    @(negedge clk);
  endtask

  // Valid for the current stage on the dly-th cycle after its start pulse.
  function automatic logic [N-1:0] auto_v(input int dly);
    logic [N-1:0] one = 1;
    if (m_act && !m_fresh && m_wait == dly - 1) return one << m_stage;
    return '0;
  endfunction

  task automatic clear_obs();
    starts_seen.delete(); loads_seen = '0; done_seen = 0; clr_seen = 0;
  endtask

  task automatic run_frame(input int dly);
    cyc(1, 0, 0, '0);
    for (int k = 0; k < 200 && m_act; k++) cyc(0, 0, 0, auto_v(dly));
  endtask

  int c0;
  bit cleared;

  initial begin
    model_reset();
    clear_obs();
    repeat (2) @(negedge clk);
    check_outputs();
    rst_n = 1'b1;
    cyc(0, 0, 0, '0);

    // Full frame, valid 3 cycles after each start.
    clear_obs();
    run_frame(3);
    cyc(0, 0, 0, '0);
    check("start_count", starts_seen.size(), N);
    for (int i = 0; i < N; i++)
      if (i < starts_seen.size()) check("start_order", starts_seen[i], 32'd1 << i);
    check("load_set", loads_seen, 6'b011010);
    check("done_once", done_seen, 1);
    check("cnt_one", frame_cnt, 1);

    // Stage 2 never answers: timeout.
    clear_obs();
    cyc(1, 0, 0, '0);
    for (int k = 0; k < 200 && m_act; k++) cyc(0, 0, 0, (m_stage < 2) ? auto_v(2) : '0);
    cyc(0, 0, 0, '0);
    check("tmo_err", timeout_err, 1);
    check("tmo_stage", err_stage, 2);
    check("tmo_busy", busy, 0);
    check("tmo_nodone", done_seen, 0);
    run_frame(1);
    check("tmo_cleared", timeout_err, 0);
    cyc(0, 0, 0, '0);

    // Overrun and back-to-back frames with start held across frame_done.
    c0 = m_cnt;
    cyc(1, 0, 0, '0);
    cyc(1, 0, 0, '0);
    for (int k = 0; k < 200 && m_act; k++) cyc(m_stage == N - 1, 0, 0, auto_v(2));
    cyc(1, 0, 0, '0);
    check("b2b_start", stage_start, 1);
    cyc(1, 0, 0, '0);
    check("ovr_set", overrun, 1);
    for (int k = 0; k < 200 && m_act; k++) cyc(0, 0, 0, auto_v(2));
    cyc(0, 0, 0, '0);
    check("cnt_two", frame_cnt, (c0 + 2) % 16);

    // state_clear during stage 3 is deferred past frame_done.
    clear_obs();
    cleared = 0;
    cyc(1, 0, 0, '0);
    for (int k = 0; k < 200 && m_act; k++) begin
      if (m_stage == 3 && !m_fresh && !cleared) begin
        cleared = 1; cyc(0, 0, 1, auto_v(2));
      end else begin
        cyc(0, 0, 0, auto_v(2));
      end
    end
    cyc(0, 0, 0, '0);
    check("clr_deferred", clr_seen, 0);
    check("clr_done_cycle", done_seen, 1);
    cyc(0, 0, 0, '0);
    cyc(0, 0, 0, '0);
    check("clr_once", clr_seen, 1);

    // Abort beats stage 4 valid.
    clear_obs();
    cyc(1, 0, 0, '0);
    for (int k = 0; k < 200 && m_act && !(m_stage == 4 && !m_fresh); k++)
      cyc(0, 0, 0, auto_v(1));
    cyc(0, 1, 0, 6'b010000);
    cyc(0, 0, 0, '0);
    check("abort_busy", busy, 0);
    check("abort_noload4", loads_seen[4], 0);
    check("abort_nodone", done_seen, 0);

    // Run frames up to the wrap of the 4-bit counter.
    for (int f = 0; f < 20 && m_cnt != 15; f++) begin run_frame(1); cyc(0, 0, 0, '0); end
    run_frame(1);
    cyc(0, 0, 0, '0);
    check("cnt_wrap", frame_cnt, 0);

    // Asynchronous reset in the middle of a frame.
    cyc(1, 0, 0, '0);
    cyc(0, 0, 0, '0);
    cyc(0, 0, 1, '0);
    cyc(1, 0, 0, '0);
    #2 rst_n = 1'b0;
    start = 0; abort = 0; state_clear = 0; stage_valid = '0;
    #1;
    model_reset();
    check_outputs();
    check("rst_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(0, 0, 0, '0);
    cyc(0, 0, 0, '0);
    check("rst_noclr", state_clr, 0);
    cyc(1, 0, 0, '0);
    check("rst_stage0", stage_start, 1);
    for (int k = 0; k < 200 && m_act; k++) cyc(0, 0, 0, auto_v(2));

    // Random traffic.
    for (int k = 0; k < 1500; k++)
      cyc($urandom_range(0, 9) == 0, $urandom_range(0, 29) == 0, $urandom_range(0, 19) == 0,
          N'($urandom & $urandom));
    check_outputs();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
